sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Shares the single SDRAM controller command port between two clients: the LCD scan-out reader (client A, high priority) and the fractal compute engine (client B, default owner). Client B uses the existing Requested/Yield handshake. Client A uses a level request and grant. The arbiter sits between both clients and the SDRAM controller. It multiplexes command, address and write data toward the controller and steers the beat strobes back to the owner. A burst cap on client A guarantees client B forward progress.

## Interface
Parameters:
- A_MAX_BURSTS, 4: A bursts allowed per tenure before a forced handback.
- B_MIN_CYCLES, 64: guaranteed B window after a forced handback.
- YIELD_TIMEOUT, 1024: cycles in S_REQ before the timeout flag is set.

Ports (clock and reset first):
- i_Clk  in  1  system clock
- i_Rst_n  in  1  reset; asynchronous, active-low
- i_A_Req  in  1  A wants the SDRAM (level)
- o_A_Grant  out  1  A owns the controller port
- i_A_Command  in  2  A command (CMD_IDLE/READ/WRITE)
- i_A_Data_Address  in  22  A word address
- i_A_Data_Write  in  32  A write data
- o_A_Data_Read_Valid  out  1  read beat strobe for A
- o_A_Data_Write_Done  out  1  write beat strobe for A
- o_B_SDRAM_Requested  out  1  asks B to yield
- i_B_SDRAM_Yield  in  1  B is idle and will stay idle while Requested is high
- i_B_Command  in  2  B command
- i_B_Data_Address  in  22  B word address
- i_B_Data_Write  in  32  B write data
- o_B_Data_Read_Valid  out  1  read beat strobe for B
- o_B_Data_Write_Done  out  1  write beat strobe for B
- o_Command  out  2  to controller
- o_Data_Address  out  22  to controller
- o_Data_Write  out  32  to controller
- i_Data_Read_Valid  in  1  from controller
- i_Data_Write_Done  in  1  from controller
- o_Yield_Timeout  out  1  sticky: B failed to yield in time

Read data (i_Data_Read) is wired from the controller to both clients directly and is not routed through this block.

## Operation
States (registered):
- S_B: B owns.
  - If i_A_Req=1, go to S_REQ.
- S_REQ: B still owns; o_B_SDRAM_Requested=1.
  - B may finish its current burst.
  - If i_B_SDRAM_Yield=1, go to S_A.
  - If i_A_Req drops first, return to S_B.
- S_A: A owns; o_A_Grant=1; o_B_SDRAM_Requested stays 1.
  - Exit when i_A_Command=CMD_IDLE and either condition holds:
    - i_A_Req=0: go to S_B.
    - burst_cnt=A_MAX_BURSTS: go to S_B_MIN.
  - While i_A_Command≠CMD_IDLE the arbiter never leaves S_A.
- S_B_MIN: B owns; i_A_Req is ignored.
  - A down-counter loaded with B_MIN_CYCLES-1 counts to 0, then go to S_B.

Datapath mux:
- The mux is combinational from registered state.
- In S_A it selects A's command, address and write data.
- In every other state it selects B's.

Beat steering:
- The controller strobes (i_Data_Read_Valid, i_Data_Write_Done) are routed combinationally to the current owner.
- The non-owner's strobes are held at 0.

Burst counter:
- Counts A beats (read valid or write done) while in S_A.
- Every READ_BURST_LENGTH beats, burst_cnt increments.
- burst_cnt saturates at A_MAX_BURSTS.
- Beat and burst counts clear on entry to S_A.

Yield timeout:
- A counter runs only in S_REQ.
- When it reaches YIELD_TIMEOUT, o_Yield_Timeout is set.
- The flag stays set until reset.
- The counter clears on leaving S_REQ.

## Timing
- Reset: state=S_B, all counters 0, o_A_Grant=0, o_B_SDRAM_Requested=0, o_Yield_Timeout=0, all strobe outputs 0.
- During reset o_Command/o_Data_Address/o_Data_Write follow B's inputs; B must drive CMD_IDLE out of reset.
- Assertion of i_A_Req during reset is ignored.
- Handover latency:
  - i_A_Req high at edge N gives o_B_SDRAM_Requested at N+1.
  - With i_B_SDRAM_Yield already high, o_A_Grant is high at N+2.
  - A may issue its command in the same cycle o_A_Grant is high.
- Release:
  - A exit condition true at edge M drops o_A_Grant at M+1.
  - On release to S_B (i_A_Req=0), o_B_SDRAM_Requested also drops at M+1.
  - On release to S_B_MIN (burst cap), o_B_SDRAM_Requested drops at M+1 even though i_A_Req is still high.
- Beat in the same cycle as the exit condition: the beat is steered to A, because state changes only at the edge.
- i_A_Req toggling during S_A has no effect until i_A_Command is IDLE.
- Mid-operation reset returns to S_B immediately. The controller is then responsible for aborting its own burst.

## Structure
- Use the existing shared header sdram.vh for CMD_IDLE=2'd0, CMD_READ=2'd1, CMD_WRITE=2'd2 and READ_BURST_LENGTH.
- Add state encodings S_B/S_REQ/S_A/S_B_MIN to sdram.vh so the test bench can probe state.
- No sub-module. One FSM with three counters; the mux is local logic.

## Test plan
- Idle handover:
  - Stimulus: B idle with yield held 1; pulse i_A_Req at cycle 10; A does one READ burst and then drops i_A_Req.
  - Required: Requested=1 at 11, Grant=1 at 12, READ_BURST_LENGTH beats go only to A, Grant=0 and Requested=0 one cycle after A returns IDLE.
- B mid-burst:
  - Stimulus: B in WRITE burst, yield 0; A requests.
  - Required: Grant stays 0 and B keeps receiving Write_Done until B goes IDLE and yields; Grant rises the next cycle.
- Burst cap:
  - Stimulus: A_MAX_BURSTS=2; A holds i_A_Req=1 and issues back-to-back READs.
  - Required: after 2×READ_BURST_LENGTH beats plus A IDLE, Grant=0 and Requested=0 for 64 cycles with i_A_Req=1; re-request follows.
- Yield timeout:
  - Stimulus: YIELD_TIMEOUT=16; B never yields.
  - Required: o_Yield_Timeout=1 after 16 cycles in S_REQ; the flag remains 1 after A withdraws.
- Steering isolation:
  - Stimulus: random controller strobes across handovers.
  - Required: the non-owner's Read_Valid and Write_Done are never 1.
- Reset in S_A:
  - Stimulus: assert i_Rst_n=0 mid A burst.
  - Required: Grant=0 and Requested=0 asynchronously; the mux selects B.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg
// Shared SDRAM command encodings, burst length and the arbiter state
// encoding. The state encoding is public so benches and checkers can
// compare against the arbiter's o_State debug output.
package sdram_arbiter_pkg;

  // Controller command encodings
  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  // Beats per controller burst
  localparam int READ_BURST_LENGTH = 8;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    S_B     = 2'd0,  // B owns the controller port
    S_REQ   = 2'd1,  // B owns, asked to yield
    S_A     = 2'd2,  // A owns
    S_B_MIN = 2'd3   // B owns, guaranteed window after A hit its burst cap
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares the SDRAM controller command port between client A (LCD scan-out,
// high priority, level request/grant) and client B (fractal engine, default
// owner, Requested/Yield handshake). Command, address and write data are
// muxed toward the controller; beat strobes are steered back to the owner.
// A cap on A bursts per tenure forces a handback so B always progresses.
//
// Handshakes:
//   A: i_A_Req is a level request. o_A_Grant high means A's command,
//      address and write data drive the controller this cycle. A keeps
//      ownership while i_A_Command != CMD_IDLE.
//   B: o_B_SDRAM_Requested asks B to stop; i_B_SDRAM_Yield high means B is
//      idle and stays idle for as long as Requested remains high.
//
// Ports:
//   i_Clk, i_Rst_n              clock, async active-low reset
//   i_A_*, o_A_*                client A request/grant, command bus, strobes
//   i_B_*, o_B_*                client B handshake, command bus, strobes
//   o_Command/o_Data_*          muxed bus to the controller
//   i_Data_Read_Valid/Write_Done beat strobes from the controller
//   o_Yield_Timeout             sticky flag: B took too long to yield
//   o_State                     debug view of the ownership state
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int A_MAX_BURSTS  = 4,
  parameter int B_MIN_CYCLES  = 64,
  parameter int YIELD_TIMEOUT = 1024
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_A_Req,
  output logic        o_A_Grant,
  input  logic [1:0]  i_A_Command,
  input  logic [21:0] i_A_Data_Address,
  input  logic [31:0] i_A_Data_Write,
  output logic        o_A_Data_Read_Valid,
  output logic        o_A_Data_Write_Done,
  output logic        o_B_SDRAM_Requested,
  input  logic        i_B_SDRAM_Yield,
  input  logic [1:0]  i_B_Command,
  input  logic [21:0] i_B_Data_Address,
  input  logic [31:0] i_B_Data_Write,
  output logic        o_B_Data_Read_Valid,
  output logic        o_B_Data_Write_Done,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  output logic [31:0] o_Data_Write,
  input  logic        i_Data_Read_Valid,
  input  logic        i_Data_Write_Done,
  output logic        o_Yield_Timeout,
  output logic [1:0]  o_State
);

  localparam int BEAT_W  = (READ_BURST_LENGTH > 1) ? $clog2(READ_BURST_LENGTH) : 1;
  localparam int BURST_W = $clog2(A_MAX_BURSTS + 1);
  localparam int BMIN_W  = (B_MIN_CYCLES > 1) ? $clog2(B_MIN_CYCLES) : 1;
  localparam int YT_W    = $clog2(YIELD_TIMEOUT + 1);

  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(READ_BURST_LENGTH - 1);
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(A_MAX_BURSTS);
  localparam logic [BMIN_W-1:0]  BMIN_LOAD = BMIN_W'(B_MIN_CYCLES - 1);
  localparam logic [YT_W-1:0]    YT_LAST   = YT_W'(YIELD_TIMEOUT - 1);
  localparam logic [YT_W-1:0]    YT_FULL   = YT_W'(YIELD_TIMEOUT);

  arb_state_t state, next_state;

  logic [BEAT_W-1:0]  beat_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BMIN_W-1:0]  bmin_cnt;
  logic [YT_W-1:0]    yield_cnt;
  logic               timeout_flag;

  logic beat;
  logic a_idle;
  logic a_sel;

  assign beat   = i_Data_Read_Valid | i_Data_Write_Done;
  assign a_idle = (i_A_Command == CMD_IDLE);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_B;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A never loses the port mid-command; a dropped request
  // wins over the burst cap so a voluntary release skips the B window.
  always_comb begin
    next_state = state;
    case (state)
      S_B: begin
        if (i_A_Req) next_state = S_REQ;
      end
      S_REQ: begin
        if (!i_A_Req)             next_state = S_B;
        else if (i_B_SDRAM_Yield) next_state = S_A;
      end
      S_A: begin
        if (a_idle) begin
          if (!i_A_Req)                    next_state = S_B;
          else if (burst_cnt == BURST_CAP) next_state = S_B_MIN;
        end
      end
      S_B_MIN: begin
        if (bmin_cnt == '0) next_state = S_B;
      end
      default: next_state = S_B;
    endcase
  end

  // Output logic: everything below is decoded from the registered state,
  // so ownership can only change at a clock edge (or asynchronously on reset).
  always_comb begin
    a_sel               = (state == S_A);
    o_A_Grant           = a_sel;
    o_B_SDRAM_Requested = (state == S_REQ) || (state == S_A);
    o_A_Data_Read_Valid = a_sel  & i_Data_Read_Valid;
    o_A_Data_Write_Done = a_sel  & i_Data_Write_Done;
    o_B_Data_Read_Valid = !a_sel & i_Data_Read_Valid;
    o_B_Data_Write_Done = !a_sel & i_Data_Write_Done;
    o_Command           = a_sel ? i_A_Command      : i_B_Command;
    o_Data_Address      = a_sel ? i_A_Data_Address : i_B_Data_Address;
    o_Data_Write        = a_sel ? i_A_Data_Write   : i_B_Data_Write;
  end

  // A beat/burst counters; held clear outside S_A so each tenure starts at 0.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else if (state != S_A) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else if (beat) begin
      if (beat_cnt == BEAT_LAST) begin
        beat_cnt <= '0;
        if (burst_cnt != BURST_CAP) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // B guaranteed window: loaded on entry, leaves S_B_MIN after reaching 0,
  // so B gets exactly B_MIN_CYCLES cycles.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bmin_cnt <= '0;
    end else if (state != S_B_MIN && next_state == S_B_MIN) begin
      bmin_cnt <= BMIN_LOAD;
    end else if (state == S_B_MIN && bmin_cnt != '0) begin
      bmin_cnt <= bmin_cnt - 1'b1;
    end
  end

  // Yield timeout: counts cycles spent in S_REQ; the flag sets at the edge
  // that completes the YIELD_TIMEOUT-th cycle and is sticky until reset.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      yield_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == S_REQ && next_state == S_REQ) begin
        if (yield_cnt != YT_FULL) yield_cnt <= yield_cnt + 1'b1;
      end else begin
        yield_cnt <= '0;
      end
      if (state == S_REQ && yield_cnt == YT_LAST) timeout_flag <= 1'b1;
    end
  end

  assign o_Yield_Timeout = timeout_flag;
  assign o_State         = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Randomized bench for sdram_arbiter with a behavioural ownership model.
// Inputs change on the falling edge, outputs are checked 1 ns later, and
// the model advances on the rising edge from the same input values.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int A_MAX  = 2;
  localparam int B_MIN  = 64;
  localparam int YT     = 16;
  localparam int RBL    = READ_BURST_LENGTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, a_grant, a_rv, a_wd;
  logic [1:0]  a_cmd;
  logic [21:0] a_addr;
  logic [31:0] a_wdata;
  logic        b_requested, b_yield, b_rv, b_wd;
  logic [1:0]  b_cmd;
  logic [21:0] b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  c_cmd;
  logic [21:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_rv, c_wd, yield_timeout;
  logic [1:0]  dbg_state;

  sdram_arbiter #(
    .A_MAX_BURSTS (A_MAX),
    .B_MIN_CYCLES (B_MIN),
    .YIELD_TIMEOUT(YT)
  ) dut (
    .i_Clk              (clk),
    .i_Rst_n            (rst_n),
    .i_A_Req            (a_req),
    .o_A_Grant          (a_grant),
    .i_A_Command        (a_cmd),
    .i_A_Data_Address   (a_addr),
    .i_A_Data_Write     (a_wdata),
    .o_A_Data_Read_Valid(a_rv),
    .o_A_Data_Write_Done(a_wd),
    .o_B_SDRAM_Requested(b_requested),
    .i_B_SDRAM_Yield    (b_yield),
    .i_B_Command        (b_cmd),
    .i_B_Data_Address   (b_addr),
    .i_B_Data_Write     (b_wdata),
    .o_B_Data_Read_Valid(b_rv),
    .o_B_Data_Write_Done(b_wd),
    .o_Command          (c_cmd),
    .o_Data_Address     (c_addr),
    .o_Data_Write       (c_wdata),
    .i_Data_Read_Valid  (c_rv),
    .i_Data_Write_Done  (c_wd),
    .o_Yield_Timeout    (yield_timeout),
    .o_State            (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int a_beats_obs = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ownership described by the rules: who owns, whether B has been asked,
  // how much of B's guaranteed window is left, beats A has taken this tenure.
  bit m_a_owns;
  bit m_asking;
  int m_guard_left;
  int m_a_beats;
  int m_wait;
  bit m_timeout;

  task automatic model_reset();
    m_a_owns = 0; m_asking = 0; m_guard_left = 0;
    m_a_beats = 0; m_wait = 0; m_timeout = 0;
  endtask

  task automatic model_step();
    bit beat;
    int bursts;
    beat = c_rv | c_wd;
    if (m_a_owns) begin
      bursts = m_a_beats / RBL;
      if (bursts > A_MAX) bursts = A_MAX;
      if (beat) m_a_beats++;
      if (a_cmd == CMD_IDLE && (!a_req || bursts == A_MAX)) begin
        m_a_owns = 0;
        if (a_req) m_guard_left = B_MIN;
      end
    end else if (m_guard_left > 0) begin
      m_guard_left--;
    end else if (m_asking) begin
      m_wait++;
      if (m_wait >= YT) m_timeout = 1;
      if (!a_req) begin
        m_asking = 0; m_wait = 0;
      end else if (b_yield) begin
        m_asking = 0; m_wait = 0; m_a_owns = 1; m_a_beats = 0;
      end
    end else if (a_req) begin
      m_asking = 1;
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_a_owns)              return S_A;
    else if (m_guard_left > 0) return S_B_MIN;
    else if (m_asking)         return S_REQ;
    else                       return S_B;
  endfunction

  // Compare all outputs against the model for the current cycle.
  task automatic check_outputs();
    logic [8:0] e;
    logic [1:0] e_cmd;
    logic [21:0] e_addr;
    logic [31:0] e_wdata;
    exp_q.push_back({m_a_owns, (m_asking | m_a_owns), m_timeout,
                     m_a_owns & c_rv, m_a_owns & c_wd,
                     !m_a_owns & c_rv, !m_a_owns & c_wd, model_state()});
    e = exp_q.pop_front();
    check("grant",      a_grant,       e[8]);
    check("requested",  b_requested,   e[7]);
    check("timeout",    yield_timeout, e[6]);
    check("a_rv",       a_rv,          e[5]);
    check("a_wd",       a_wd,          e[4]);
    check("b_rv",       b_rv,          e[3]);
    check("b_wd",       b_wd,          e[2]);
    check("state",      dbg_state,     e[1:0]);
    e_cmd   = m_a_owns ? a_cmd   : b_cmd;
    e_addr  = m_a_owns ? a_addr  : b_addr;
    e_wdata = m_a_owns ? a_wdata : b_wdata;
    check("mux_cmd",    c_cmd,   e_cmd);
    check("mux_addr",   c_addr,  e_addr);
    check("mux_wdata",  c_wdata, e_wdata);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with inputs already set.
  task automatic tick();
    #1;
    check_outputs();
    a_beats_obs += int'(a_rv | a_wd);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
  endtask

  task automatic rand_bus();
    a_addr  = 22'($urandom);
    a_wdata = $urandom;
    b_addr  = 22'($urandom);
    b_wdata = $urandom;
  endtask

  task automatic rand_strobes();
    c_rv = 1'($urandom_range(0, 1));
    c_wd = ($urandom_range(0, 3) == 0);
  endtask

  task automatic quiet();
    a_cmd = CMD_IDLE; b_cmd = CMD_IDLE; c_rv = 0; c_wd = 0;
  endtask

  task automatic wait_grant(input int budget);
    int n;
    n = 0;
    while (!m_a_owns && n < budget) begin
      rand_bus();
      tick();
      n++;
    end
    check("wait_grant", m_a_owns, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    a_req = 1; b_yield = 1; quiet(); rand_bus();
    // Reset with A requesting: request must be ignored.
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1;
    repeat (4) begin a_req = 0; tick(); end

    // Idle handover: B yields immediately, A does one READ burst.
    b_yield = 1;
    a_req = 1;
    tick();                                  // edge N
    check("req_latency", b_requested, 1'b1); // sampled after N+1... checked next
    wait_grant(4);
    a_beats_obs = 0;
    for (int n = 0; n < 200 && a_beats_obs < RBL; n++) begin
      a_cmd = CMD_READ; rand_strobes(); c_wd = 0; rand_bus();
      tick();
    end
    check("a_burst_beats", a_beats_obs, RBL);
    a_cmd = CMD_IDLE; a_req = 0; quiet();
    tick();
    tick();
    check("release_grant", a_grant, 1'b0);
    check("release_req",   b_requested, 1'b0);

    // B mid-burst: B writes without yielding while A waits.
    b_yield = 0; b_cmd = CMD_WRITE; a_req = 1;
    repeat (10) begin
      c_wd = 1'($urandom_range(0, 1)); c_rv = 0; rand_bus();
      tick();
    end
    b_cmd = CMD_IDLE; c_wd = 0; b_yield = 1;
    wait_grant(4);
    a_req = 0;
    tick();
    tick();

    // Burst cap: A keeps requesting and reads back to back.
    a_req = 1; b_yield = 1;
    wait_grant(6);
    a_beats_obs = 0;
    for (int n = 0; n < 400 && a_beats_obs < A_MAX * RBL; n++) begin
      a_cmd = CMD_READ; rand_strobes(); rand_bus();
      tick();
    end
    check("cap_beats", a_beats_obs, A_MAX * RBL);
    a_cmd = CMD_IDLE; quiet();
    tick();
    for (int n = 0; n < B_MIN; n++) begin
      rand_bus();
      tick();
      if (n == 0 || n == B_MIN - 1) check("cap_window_grant", a_grant, 1'b0);
    end
    wait_grant(6);
    a_req = 0;
    tick();
    tick();

    // Yield timeout: B never yields, then A withdraws.
    b_yield = 0; a_req = 1;
    repeat (YT + 4) begin rand_bus(); tick(); end
    check("timeout_set", yield_timeout, 1'b1);
    a_req = 0;
    repeat (4) tick();
    check("timeout_sticky", yield_timeout, 1'b1);

    // Random traffic across many handovers; steering checked every cycle.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) a_req = ~a_req;
      b_yield = ($urandom_range(0, 3) != 0);
      a_cmd   = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) a_cmd = CMD_IDLE;
      b_cmd   = 2'($urandom_range(0, 2));
      rand_strobes();
      rand_bus();
      tick();
    end

    // Reset in the middle of an A burst.
    quiet(); a_req = 1; b_yield = 1;
    repeat (2) tick();
    wait_grant(B_MIN + 8);
    a_cmd = CMD_READ; c_rv = 1;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    check("rst_grant",     a_grant, 1'b0);
    check("rst_requested", b_requested, 1'b0);
    check("rst_mux_cmd",   c_cmd, b_cmd);
    check("rst_mux_addr",  c_addr, b_addr);
    check("rst_a_rv",      a_rv, 1'b0);
    model_reset();
    @(negedge clk);
    quiet();
    tick();
    check("rst_timeout_clear", yield_timeout, 1'b0);
    rst_n = 1;
    a_req = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time guard
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
